// File: rtl/axi_read_arbiter_pkg.sv
// rtl/axi_read_arbiter_pkg.sv - shared constants and types for the PageRank AXI read arbiter
package axi_read_arbiter_pkg;

    // Requester indices, issued as arid and returned as rid.
    localparam int RID_VERT = 0;   // vertex array
    localparam int RID_IE   = 1;   // in-edge array
    localparam int RID_PR   = 2;   // PageRank-value fetch

    localparam logic [2:0] AR_SIZE_64B   = 3'b110;
    localparam logic [7:0] AR_LEN_SINGLE = 8'd0;

    // The AR stage is a single register: empty, or holding one request until arready.
    typedef enum logic {
        AR_EMPTY = 1'b0,
        AR_HOLD  = 1'b1
    } ar_state_t;

endpackage

// File: rtl/axi_read_arbiter_rr_arbiter.sv
// rtl/axi_read_arbiter_rr_arbiter.sv - round-robin arbiter with one optional strict-priority requester
//
// Ports:
//   clk, reset_n  clock, async active-low reset
//   elig          eligible mask
//   advance       grant is consumed this cycle; moves the pointer after a non-priority grant
//   grant         one-hot grant
//   grant_idx     index of the granted requester
//   grant_any     some requester is granted
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PRIO  = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     elig,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    localparam bit PRIO_EN  = (PRIO < N);
    localparam int PRIO_IDX = PRIO_EN ? PRIO : 0;

    // Search start: one past the last non-priority grant.
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] idx_v;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx_v     = '0;
        if (PRIO_EN && elig[PRIO_IDX]) begin
            grant[PRIO_IDX] = 1'b1;
            grant_idx       = IDX_W'(PRIO_IDX);
            grant_any       = 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                idx_v = IDX_W'((int'(ptr_q) + k) % N);
                if (!grant_any && elig[idx_v] && !(PRIO_EN && idx_v == IDX_W'(PRIO_IDX))) begin
                    grant[idx_v] = 1'b1;
                    grant_idx    = idx_v;
                    grant_any    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (advance && grant_any && !(PRIO_EN && grant_idx == IDX_W'(PRIO_IDX))) begin
            ptr_q <= IDX_W'((int'(grant_idx) + 1) % N);
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - shares one AXI read master between the PageRank read streams
//
// Ports:
//   clk, reset_n             clock, async active-low reset
//   req_valid/req_addr       per-requester read request and byte address (slot i = [i*ADDR_W +: ADDR_W])
//   req_ready                one-cycle pulse: request i captured this cycle
//   ar*_m                    AXI AR channel (id = requester index, 64 B single-beat, line aligned)
//   r*_m                     AXI R channel; rready_m tied high
//   rsp_valid/rsp_data       R beat steered to the requester named by rid_m
//   outstanding              per-requester in-flight count, 4 bits each
//   idle                     no AR pending and nothing in flight
//   err_rid                  sticky: R beat with unknown rid, or R last with nothing in flight
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 512,
    parameter int MAX_OUT  = 4,
    parameter int PRIO_REQ = RID_PR
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        req_ready,
    output logic [15:0]             arid_m,
    output logic [ADDR_W-1:0]       araddr_m,
    output logic [7:0]              arlen_m,
    output logic [2:0]              arsize_m,
    output logic                    arvalid_m,
    input  logic                    arready_m,
    input  logic [15:0]             rid_m,
    input  logic [DATA_W-1:0]       rdata_m,
    input  logic                    rlast_m,
    input  logic                    rvalid_m,
    output logic                    rready_m,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [N_REQ*4-1:0]      outstanding,
    output logic                    idle,
    output logic                    err_rid
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    ar_state_t        state_q, state_d;
    logic [IDX_W-1:0] arid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] sel_addr;
    logic [CNT_W-1:0] count_q [N_REQ];

    logic [N_REQ-1:0] elig, grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    logic             load_en, ar_fire, bad_dec, all_zero;

    assign arvalid_m = (state_q == AR_HOLD);
    // The AR register may be refilled when empty or when its content leaves this cycle.
    assign load_en   = !arvalid_m || arready_m;
    assign ar_fire   = arvalid_m && arready_m;

    // The held AR counts against its requester's budget until it is accepted.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req_valid[i] &&
                      ((int'(count_q[i]) + int'(arvalid_m && arid_q == IDX_W'(i))) < MAX_OUT);
        end
    end

    rr_arbiter #(
        .N    (N_REQ),
        .PRIO (PRIO_REQ)
    ) u_rr (
        .clk       (clk),
        .reset_n   (reset_n),
        .elig      (elig),
        .advance   (load_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    assign req_ready = (reset_n && load_en) ? grant : '0;

    always_comb begin
        state_d = state_q;
        if (load_en) state_d = grant_any ? AR_HOLD : AR_EMPTY;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= AR_EMPTY;
            arid_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_en && grant_any) begin
                arid_q <= grant_idx;
                addr_q <= {sel_addr[ADDR_W-1:6], 6'b0};
            end
        end
    end

    // A simultaneous accept and last-beat return cancel out; a return at zero is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_REQ; i++) count_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if ((ar_fire && arid_q == IDX_W'(i)) &&
                    !(rvalid_m && rlast_m && rid_m == 16'(i) && count_q[i] != '0)) begin
                    count_q[i] <= count_q[i] + 1'b1;
                end else if (!(ar_fire && arid_q == IDX_W'(i)) &&
                             (rvalid_m && rlast_m && rid_m == 16'(i) && count_q[i] != '0)) begin
                    count_q[i] <= count_q[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        bad_dec     = 1'b0;
        all_zero    = 1'b1;
        rsp_valid   = '0;
        outstanding = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (rvalid_m && rlast_m && rid_m == 16'(i) && count_q[i] == '0) bad_dec = 1'b1;
            if (count_q[i] != '0) all_zero = 1'b0;
            rsp_valid[i]        = rvalid_m && (rid_m == 16'(i));
            outstanding[i*4 +: 4] = 4'(count_q[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_rid <= 1'b0;
        end else if ((rvalid_m && rid_m >= 16'(N_REQ)) || bad_dec) begin
            err_rid <= 1'b1;
        end
    end

    assign idle     = !arvalid_m && all_zero;
    assign arid_m   = 16'(arid_q);
    assign araddr_m = addr_q;
    assign arlen_m  = AR_LEN_SINGLE;
    assign arsize_m = AR_SIZE_64B;
    assign rready_m = 1'b1;
    assign rsp_data = rdata_m;

endmodule
